// File: rtl/buffered_regfile.sv
// 32x32 register file with a DEPTH-entry posted-write FIFO; reads forward the youngest
// matching pending write ahead of the array contents.
module buffered_regfile #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     ctrl_writeEnable,
  input  logic [4:0]               ctrl_writeReg,
  input  logic [31:0]              data_writeReg,
  output logic                     write_ready,
  input  logic                     ctrl_drainHold,
  input  logic [4:0]               ctrl_readRegA,
  input  logic [4:0]               ctrl_readRegB,
  output logic [31:0]              data_readRegA,
  output logic [31:0]              data_readRegB,
  output logic [$clog2(DEPTH):0]   buffer_count
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]    fidx [DEPTH];
  logic [31:0]   fdat [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [31:0]   regs [32];
  logic [31:0]   row_en;
  logic          accept, enq, drain;
  logic [AW-1:0] pos;

  assign buffer_count = count;
  assign write_ready  = (count < (AW+1)'(DEPTH));
  assign accept       = ctrl_writeEnable & write_ready;
  assign enq          = accept & (ctrl_writeReg != 5'd0);
  assign drain        = (count != '0) & ~ctrl_drainHold;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq)   wptr <= wptr + AW'(1);
      if (drain) rptr <= rptr + AW'(1);
      case ({enq, drain})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: only slots inside [rptr, rptr+count) are ever observed.
  always_ff @(posedge clock) begin
    if (enq) begin
      fidx[wptr] <= ctrl_writeReg;
      fdat[wptr] <= data_writeReg;
    end
  end

  always_comb begin
    row_en = '0;
    if (drain) row_en[fidx[rptr]] = 1'b1;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int unsigned r = 0; r < 32; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < 32; r++)
        if (r != 0 && row_en[r]) regs[r] <= fdat[rptr];
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    data_readRegB = regs[ctrl_readRegB];
    pos = rptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = rptr + AW'(k);
      if ((AW+1)'(k) < count) begin
        if (fidx[pos] == ctrl_readRegA) data_readRegA = fdat[pos];
        if (fidx[pos] == ctrl_readRegB) data_readRegB = fdat[pos];
      end
    end
    if (ctrl_readRegA == 5'd0) data_readRegA = '0;
    if (ctrl_readRegB == 5'd0) data_readRegB = '0;
  end

endmodule

// File: tb/tb_buffered_regfile.sv
// Self-checking bench for buffered_regfile: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_buffered_regfile;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clock;
  logic          ctrl_reset;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic          write_ready;
  logic          ctrl_drainHold;
  logic [4:0]    ctrl_readRegA, ctrl_readRegB;
  logic [31:0]   data_readRegA, data_readRegB;
  logic [CW-1:0] buffer_count;

  buffered_regfile #(.DEPTH(DEPTH)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .write_ready(write_ready),
    .ctrl_drainHold(ctrl_drainHold),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .buffer_count(buffer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: committed array plus an ordered list of pending writes.
  typedef struct { logic [4:0] idx; logic [31:0] data; } pend_t;
  logic [31:0] m_arr [32];
  pend_t       m_q [$];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_arr[i] = '0;
    m_q.delete();
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] i);
    if (i == 0) return '0;
    for (int k = m_q.size() - 1; k >= 0; k--)
      if (m_q[k].idx == i) return m_q[k].data;
    return m_arr[i];
  endfunction

  function automatic void model_edge(logic we, logic [4:0] wr, logic [31:0] wd, logic hold);
    pend_t e;
    bit ready;
    ready = (m_q.size() < DEPTH);
    if (m_q.size() > 0 && !hold) begin
      e = m_q.pop_front();
      m_arr[e.idx] = e.data;
    end
    if (we && ready && wr != 0) begin
      e.idx = wr; e.data = wd;
      m_q.push_back(e);
    end
  endfunction

  task automatic drive(logic we, logic [4:0] wr, logic [31:0] wd, logic hold,
                       logic [4:0] ra, logic [4:0] rb);
    ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    ctrl_drainHold = hold; ctrl_readRegA = ra; ctrl_readRegB = rb;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".ready"}, 32'(write_ready), 32'(m_q.size() < DEPTH));
    chk({tag, ".count"}, 32'(buffer_count), 32'(m_q.size()));
    chk({tag, ".readA"}, data_readRegA, model_read(ctrl_readRegA));
    chk({tag, ".readB"}, data_readRegB, model_read(ctrl_readRegB));
  endtask

  // Called at a negedge: drive, check pre-edge outputs, advance one clock.
  task automatic mcyc(string tag, logic we, logic [4:0] wr, logic [31:0] wd, logic hold,
                      logic [4:0] ra, logic [4:0] rb);
    drive(we, wr, wd, hold, ra, rb);
    #1 check_model(tag);
    @(posedge clock);
    model_edge(we, wr, wd, hold);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd3, 5'd5);
    model_reset();
    #1;
    chk("rst.ready", 32'(write_ready), 32'd1);
    chk("rst.count", 32'(buffer_count), 32'd0);
    chk("rst.readA", data_readRegA, 32'd0);
    chk("rst.readB", data_readRegB, 32'd0);
    #2 ctrl_reset = 1'b1;
    @(negedge clock);
  endtask

  typedef struct {
    logic we; logic [4:0] wr; logic [31:0] wd; logic hold;
    logic [4:0] ra; logic [4:0] rb;
    int cnt; logic rdy; logic [31:0] ea; logic [31:0] eb;
  } vec_t;
  vec_t tv [$];

  function automatic void add(logic we, logic [4:0] wr, logic [31:0] wd, logic hold,
                              logic [4:0] ra, logic [4:0] rb,
                              int cnt, logic rdy, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.we = we; v.wr = wr; v.wd = wd; v.hold = hold; v.ra = ra; v.rb = rb;
    v.cnt = cnt; v.rdy = rdy; v.ea = ea; v.eb = eb;
    tv.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_reset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0);

    // Expected values are the outputs seen before each row's clock edge.
    add(1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 5'd0, 0, 1, 32'h0, 32'h0);
    add(0, 5'd0, 32'h0,        0, 5'd5, 5'd5, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    add(0, 5'd0, 32'h0,        0, 5'd5, 5'd1, 0, 1, 32'hDEADBEEF, 32'h0);
    add(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 0, 1, 32'h0, 32'h0);
    add(0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 0, 1, 32'h0, 32'hDEADBEEF);
    add(1, 5'd1, 32'd1,        1, 5'd1, 5'd0, 0, 1, 32'h0, 32'h0);
    add(1, 5'd2, 32'd2,        1, 5'd1, 5'd2, 1, 1, 32'd1, 32'h0);
    add(1, 5'd3, 32'd3,        1, 5'd2, 5'd3, 2, 1, 32'd2, 32'h0);
    add(1, 5'd4, 32'd4,        1, 5'd3, 5'd4, 3, 1, 32'd3, 32'h0);
    add(1, 5'd6, 32'd6,        1, 5'd4, 5'd6, 4, 0, 32'd4, 32'h0);
    add(0, 5'd0, 32'h0,        0, 5'd6, 5'd1, 4, 0, 32'h0, 32'd1);
    add(0, 5'd0, 32'h0,        0, 5'd1, 5'd6, 3, 1, 32'd1, 32'h0);
    add(0, 5'd0, 32'h0,        0, 5'd2, 5'd3, 2, 1, 32'd2, 32'd3);
    add(0, 5'd0, 32'h0,        0, 5'd4, 5'd6, 1, 1, 32'd4, 32'h0);
    add(0, 5'd0, 32'h0,        0, 5'd6, 5'd4, 0, 1, 32'h0, 32'd4);
    add(1, 5'd7, 32'hA,        1, 5'd7, 5'd7, 0, 1, 32'h0, 32'h0);
    add(1, 5'd7, 32'hB,        1, 5'd7, 5'd7, 1, 1, 32'hA, 32'hA);
    add(0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 2, 1, 32'hB, 32'hB);
    add(0, 5'd0, 32'h0,        0, 5'd1, 5'd7, 2, 1, 32'd1, 32'hB);
    add(0, 5'd0, 32'h0,        0, 5'd2, 5'd7, 1, 1, 32'd2, 32'hB);
    add(0, 5'd0, 32'h0,        0, 5'd7, 5'd7, 0, 1, 32'hB, 32'hB);

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].we, tv[i].wr, tv[i].wd, tv[i].hold, tv[i].ra, tv[i].rb);
      #1;
      chk($sformatf("vec%0d.count", i), 32'(buffer_count), 32'(tv[i].cnt));
      chk($sformatf("vec%0d.ready", i), 32'(write_ready), 32'(tv[i].rdy));
      chk($sformatf("vec%0d.readA", i), data_readRegA, tv[i].ea);
      chk($sformatf("vec%0d.readB", i), data_readRegB, tv[i].eb);
      @(negedge clock);
    end

    // Simultaneous enqueue and drain at count=2, across several pointer wraps.
    do_reset();
    mcyc("sim.fill", 1, 5'd10, 32'h100, 1, 5'd10, 5'd11);
    mcyc("sim.fill", 1, 5'd11, 32'h101, 1, 5'd10, 5'd11);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      mcyc("sim.run", 1, 5'(10 + (i % 4)), 32'(32'h200 + i), 0,
           5'(10 + ((i + 1) % 4)), 5'(10 + ((i + 2) % 4)));
      chk("sim.count2", 32'(buffer_count), 32'd2);
    end
    mcyc("sim.tail", 0, 5'd0, 32'h0, 0, 5'd12, 5'd13);
    mcyc("sim.tail", 0, 5'd0, 32'h0, 0, 5'd10, 5'd11);
    mcyc("sim.tail", 0, 5'd0, 32'h0, 0, 5'd12, 5'd13);

    // Reset mid-operation: pending entries must never reach the array.
    do_reset();
    mcyc("rmo.fill", 1, 5'd8,  32'h88, 1, 5'd8, 5'd9);
    mcyc("rmo.fill", 1, 5'd9,  32'h99, 1, 5'd8, 5'd9);
    mcyc("rmo.fill", 1, 5'd10, 32'hAA, 1, 5'd8, 5'd9);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd8, 5'd10);
    #1 chk("rmo.pending", 32'(buffer_count), 32'd3);
    #1 ctrl_reset = 1'b0;
    #1;
    chk("rmo.count", 32'(buffer_count), 32'd0);
    chk("rmo.ready", 32'(write_ready), 32'd1);
    chk("rmo.readA", data_readRegA, 32'd0);
    chk("rmo.readB", data_readRegB, 32'd0);
    #1 ctrl_reset = 1'b1;
    model_reset();
    @(negedge clock);
    for (int i = 0; i < 4; i++) mcyc("rmo.after", 0, 5'd0, 32'h0, 0, 5'(8 + i % 3), 5'd9);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic we, hold;
      logic [4:0] wr, ra, rb;
      we   = ($urandom_range(0, 99) < 70);
      hold = ($urandom_range(0, 99) < 40);
      wr   = 5'($urandom_range(0, 7));
      ra   = 5'($urandom_range(0, 7));
      rb   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      mcyc("rand", we, wr, $urandom, hold, ra, rb);
    end
    for (int i = 0; i < DEPTH + 1; i++) mcyc("rand.drain", 0, 5'd0, 32'h0, 0, 5'(i + 1), 5'(i + 2));
    for (int i = 0; i < 8; i++) mcyc("rand.final", 0, 5'd0, 32'h0, 0, 5'(i), 5'(i + 8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
